riscv_fetch_exec: RTL and testbench
===================================

# riscv_fetch_exec

Minimal multi-cycle RV32I initiator for the word-addressed instruction memory's read port: drives `mem_addr`/`mem_rstrb`, accepts `mem_rdata` one cycle later, then decodes and executes. It sits between the SoC clock/reset and the memory block and is the processor side of that read interface. It has no data-memory path, so loads and stores are not supported. One selectable register and a halt flag are exported for LEDs and benches.

## Interface
- `RESET_ADDR`, default 32'h0000_0000: PC value loaded on reset.
- `DBG_REG`, default 1: index (0-31) of the register mirrored on `dbg_reg`.
- `clk`  in  1: sole clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `mem_addr`  out  32: byte address of the instruction; always equals PC.
- `mem_rstrb`  out  1: read strobe; memory samples `mem_addr` on the edge where this is high.
- `mem_rdata`  in  32: instruction word, valid the cycle after the strobe edge.
- `dbg_reg`  out  32: current value of register `DBG_REG`.
- `halted`  out  1: high once EBREAK has executed.

## Operation
- States: FETCH, WAIT, EXEC, HALT.
  - FETCH: `mem_rstrb`=1. Next state is WAIT.
  - WAIT: latch `instr` from `mem_rdata`. Latch rs1v/rs2v from the register file using `mem_rdata[19:15]` and `mem_rdata[24:20]`. Next state is EXEC.
  - EXEC: compute the result, write rd, update PC. Next state is FETCH, or HALT on EBREAK.
  - HALT: terminal until reset.
- Reset values:
  - PC = RESET_ADDR.
  - state = FETCH.
  - x1-x31 = 0.
  - `halted` = 0; `dbg_reg` = 0.
  - `mem_rstrb` is gated low while `reset`=1.
- x0 always reads 0. Writes to x0 are discarded.
- Supported opcodes:
  - LUI, AUIPC, JAL, JALR.
  - BRANCH: BEQ, BNE, BLT, BGE, BLTU, BGEU.
  - OP-IMM: ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
  - OP: ADD, SUB, SLL, SLT, SLTU, XOR, OR, AND, SRL, SRA.
  - SYSTEM with `instr`=32'h0010_0073 (EBREAK).
- Any other opcode, including LOAD, STORE, FENCE and other SYSTEM encodings, executes as a NOP: PC+=4, no write.
- Arithmetic rules:
  - All arithmetic is mod 2^32.
  - Shift amount is operand[4:0].
  - instr[30] selects SUB (OP only) and arithmetic right shift (OP and OP-IMM).
  - Immediates are sign-extended per the I/S/B/U/J formats.
- Next PC:
  - Taken branch: PC+immB.
  - JAL: PC+immJ.
  - JALR: (rs1v+immI) & ~1.
  - Otherwise: PC+4.
  - PC low bits are carried as computed; memory ignores bits [1:0].
- Link value: JAL and JALR write PC+4 to rd, using the old PC.

## Timing
- Three cycles per instruction (FETCH, WAIT, EXEC), with no overlap.
- `mem_rstrb` is high only in FETCH, exactly one cycle per instruction.
- First strobe is in the first cycle with `reset`=0, at `mem_addr`=RESET_ADDR.
- Register writes and the PC update occur on the edge leaving EXEC. The next strobe already uses the new PC.
- `halted` rises on the edge leaving the EXEC of EBREAK. In HALT, `mem_rstrb`=0 and PC is frozen.
- Reset is honoured in every state, including mid-WAIT and mid-EXEC. The in-flight instruction is discarded with no register write.
- `dbg_reg` is registered and reflects writes from the following cycle onward.

## Structure
- Package `riscv_pkg` holds:
  - opcode constants;
  - funct3 constants;
  - the state enum (FETCH, WAIT, EXEC, HALT);
  - the EBREAK encoding.
- Sub-module `riscv_alu` is purely combinational.
  - Inputs: rs1v, rs2v/imm, funct3, instr[30], is_op.
  - Outputs: the result and the branch-taken flag.
- Top-level holds the FSM, PC, instr, register file, and immediate decode.

## Test plan
- **Counting loop.** Program: ADD x1,x0,x0; ADDI x2,x0,31; loop: ADDI x1,x1,1; BNE x1,x2,loop; EBREAK.
  - Required: `halted` rises exactly 195 edges after reset release, with `dbg_reg`=31.
  - `mem_rstrb` pulses exactly 65 times.
- **Jumps.** Program at 0: JAL x5,+8.
  - Required: next strobe at address 8, x5=4.
  - Then at 8: JALR x6,x5,3. Required: next fetch at 6, x6=12.
- **Arithmetic.** LUI x1,0x80000; SRAI x3,x1,4; SRLI x4,x1,4; SLTU x7,x0,x1.
  - Required: x3=32'hF800_0000, x4=32'h0800_0000, x7=1.
- **Unsupported opcodes.** An SW instruction, then word 32'h0000_0000.
  - Required: each advances PC by 4, no register changes, no halt.
- **Reset mid-instruction.** Assert `reset` for one cycle during the EXEC of ADDI x1,x0,5.
  - Required: x1 stays 0; next strobe at RESET_ADDR.
  - Required: `halted`=0; `mem_rstrb`=0 during the reset cycle.
- **x0 and halt hold.** ADDI x0,x0,7, then EBREAK, then 20 idle cycles.
  - Required: x0 reads 0; `halted` stays 1; no further strobes; PC frozen at the EBREAK address.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared constants, opcode/funct3 encodings and FSM state type for the RV32I fetch/exec core.
package riscv_pkg;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned REG_AW = 5;
   localparam int unsigned NREGS  = 32;

   // Major opcodes (instr[6:0])
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   // ALU funct3 encodings (OP / OP-IMM)
   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   // Branch funct3 encodings
   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   localparam logic [XLEN-1:0] INSTR_EBREAK = 32'h0010_0073;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      WAIT  = 2'd1,
      EXEC  = 2'd2,
      HALT  = 2'd3
   } state_t;

endpackage

// File: rtl/riscv_fetch_exec_if.sv
// Instruction-memory read port: core drives address/strobe, memory returns the word a cycle later.
interface riscv_fetch_exec_if import riscv_pkg::*; ();

   logic [XLEN-1:0] mem_addr;
   logic            mem_rstrb;
   logic [XLEN-1:0] mem_rdata;

   modport master (output mem_addr, output mem_rstrb, input mem_rdata);
   modport slave  (input mem_addr, input mem_rstrb, output mem_rdata);

endinterface

// File: rtl/riscv_alu.sv
// Combinational RV32I ALU plus branch comparator.
module riscv_alu import riscv_pkg::*; (
   input  logic [XLEN-1:0] i_a,
   input  logic [XLEN-1:0] i_b,
   input  logic [2:0]      i_funct3,
   input  logic            i_alt,
   input  logic            i_is_op,
   output logic [XLEN-1:0] o_result,
   output logic            o_taken
);

   logic [4:0] w_shamt;
   logic       w_eq;
   logic       w_lt;
   logic       w_ltu;

   // Shared comparisons used by both SLT* and branches
   always_comb begin
      w_shamt = i_b[4:0];
      w_eq    = (i_a == i_b);
      w_lt    = ($signed(i_a) < $signed(i_b));
      w_ltu   = (i_a < i_b);
   end

   // Result select; instr[30] means SUB only for OP, SRA for both shift forms
   always_comb begin
      o_result = '0;
      case (i_funct3)
         F3_ADD:  o_result = (i_is_op && i_alt) ? (i_a - i_b) : (i_a + i_b);
         F3_SLL:  o_result = i_a << w_shamt;
         F3_SLT:  o_result = {{(XLEN-1){1'b0}}, w_lt};
         F3_SLTU: o_result = {{(XLEN-1){1'b0}}, w_ltu};
         F3_XOR:  o_result = i_a ^ i_b;
         F3_SR:   o_result = i_alt ? XLEN'($signed(i_a) >>> w_shamt) : (i_a >> w_shamt);
         F3_OR:   o_result = i_a | i_b;
         F3_AND:  o_result = i_a & i_b;
         default: o_result = '0;
      endcase
   end

   // Branch condition; reserved funct3 values never branch
   always_comb begin
      o_taken = 1'b0;
      case (i_funct3)
         F3_BEQ:  o_taken = w_eq;
         F3_BNE:  o_taken = !w_eq;
         F3_BLT:  o_taken = w_lt;
         F3_BGE:  o_taken = !w_lt;
         F3_BLTU: o_taken = w_ltu;
         F3_BGEU: o_taken = !w_ltu;
         default: o_taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/riscv_fetch_exec.sv
// Multi-cycle RV32I core (FETCH/WAIT/EXEC) with no data-memory path; halts on EBREAK.
module riscv_fetch_exec import riscv_pkg::*; #(
   parameter logic [XLEN-1:0] RESET_ADDR = 32'h0000_0000,
   parameter int unsigned     DBG_REG    = 1
) (
   input  logic               clk,
   input  logic               reset,
   riscv_fetch_exec_if.master bus,
   output logic [XLEN-1:0]    dbg_reg,
   output logic               halted
);

   state_t          r_state;
   state_t          w_state_next;
   logic            w_rstrb;

   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_instr;
   logic [XLEN-1:0] r_rs1v;
   logic [XLEN-1:0] r_rs2v;
   logic [XLEN-1:0] r_regs [NREGS];
   logic            r_halted;
   logic [XLEN-1:0] r_dbg;

   logic [6:0]        w_opcode;
   logic [REG_AW-1:0] w_rd;
   logic [2:0]        w_funct3;
   logic [XLEN-1:0]   w_imm_i;
   logic [XLEN-1:0]   w_imm_b;
   logic [XLEN-1:0]   w_imm_u;
   logic [XLEN-1:0]   w_imm_j;
   logic              w_is_op;
   logic              w_is_ebreak;
   logic [XLEN-1:0]   w_op2;
   logic [XLEN-1:0]   w_alu_res;
   logic              w_taken;
   logic [XLEN-1:0]   w_pc_plus4;
   logic [XLEN-1:0]   w_next_pc;
   logic              w_wr_en;
   logic [XLEN-1:0]   w_wr_data;

   assign bus.mem_addr  = r_pc;
   assign bus.mem_rstrb = w_rstrb;
   assign dbg_reg       = r_dbg;
   assign halted        = r_halted;

   // Field extraction and sign-extended immediates of the latched instruction
   always_comb begin
      w_opcode    = r_instr[6:0];
      w_rd        = r_instr[11:7];
      w_funct3    = r_instr[14:12];
      w_imm_i     = {{20{r_instr[31]}}, r_instr[31:20]};
      w_imm_b     = {{20{r_instr[31]}}, r_instr[7], r_instr[30:25], r_instr[11:8], 1'b0};
      w_imm_u     = {r_instr[31:12], 12'h000};
      w_imm_j     = {{12{r_instr[31]}}, r_instr[19:12], r_instr[20], r_instr[30:21], 1'b0};
      w_is_op     = (w_opcode == OPC_OP);
      w_is_ebreak = (r_instr == INSTR_EBREAK);
      w_op2       = (w_is_op || (w_opcode == OPC_BRANCH)) ? r_rs2v : w_imm_i;
      w_pc_plus4  = r_pc + 32'd4;
   end

   riscv_alu u_alu (
      .i_a      (r_rs1v),
      .i_b      (w_op2),
      .i_funct3 (w_funct3),
      .i_alt    (r_instr[30]),
      .i_is_op  (w_is_op),
      .o_result (w_alu_res),
      .o_taken  (w_taken)
   );

   // Execute: writeback value/enable and next PC; unknown opcodes fall through as NOP
   always_comb begin
      w_next_pc = w_pc_plus4;
      w_wr_en   = 1'b0;
      w_wr_data = w_alu_res;
      case (w_opcode)
         OPC_LUI: begin
            w_wr_en   = 1'b1;
            w_wr_data = w_imm_u;
         end
         OPC_AUIPC: begin
            w_wr_en   = 1'b1;
            w_wr_data = r_pc + w_imm_u;
         end
         OPC_JAL: begin
            w_wr_en   = 1'b1;
            w_wr_data = w_pc_plus4;
            w_next_pc = r_pc + w_imm_j;
         end
         OPC_JALR: begin
            w_wr_en   = 1'b1;
            w_wr_data = w_pc_plus4;
            w_next_pc = (r_rs1v + w_imm_i) & ~32'd1;
         end
         OPC_BRANCH: begin
            if (w_taken) begin
               w_next_pc = r_pc + w_imm_b;
            end
         end
         OPC_OPIMM, OPC_OP: begin
            w_wr_en = 1'b1;
         end
         OPC_SYSTEM: begin
            if (w_is_ebreak) begin
               w_next_pc = r_pc;
            end
         end
         default: begin
         end
      endcase
      if (w_rd == '0) begin
         w_wr_en = 1'b0;
      end
   end

   // Next-state and read strobe; strobe is forced low during reset
   always_comb begin
      w_state_next = r_state;
      w_rstrb      = 1'b0;
      case (r_state)
         FETCH: begin
            w_rstrb      = 1'b1;
            w_state_next = WAIT;
         end
         WAIT:    w_state_next = EXEC;
         EXEC:    w_state_next = w_is_ebreak ? HALT : FETCH;
         HALT:    w_state_next = HALT;
         default: w_state_next = FETCH;
      endcase
      if (reset) begin
         w_rstrb = 1'b0;
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= FETCH;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Datapath: operand latch in WAIT, commit in EXEC; reset discards any in-flight instruction
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc     <= RESET_ADDR;
         r_instr  <= '0;
         r_rs1v   <= '0;
         r_rs2v   <= '0;
         r_halted <= 1'b0;
         r_dbg    <= '0;
         for (int i = 0; i < NREGS; i++) begin
            r_regs[i] <= '0;
         end
      end else begin
         if (r_state == WAIT) begin
            r_instr <= bus.mem_rdata;
            r_rs1v  <= r_regs[bus.mem_rdata[19:15]];
            r_rs2v  <= r_regs[bus.mem_rdata[24:20]];
         end
         if (r_state == EXEC) begin
            r_pc <= w_next_pc;
            if (w_wr_en) begin
               r_regs[w_rd] <= w_wr_data;
               if (w_rd == REG_AW'(DBG_REG)) begin
                  r_dbg <= w_wr_data;
               end
            end
            if (w_is_ebreak) begin
               r_halted <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_riscv_fetch_exec.sv
// Bench for riscv_fetch_exec: directed programs plus random programs against an instruction-level model.
module tb_riscv_fetch_exec;

   localparam logic [31:0] EBREAK = 32'h0010_0073;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] dbg_reg;
   logic        halted;

   riscv_fetch_exec_if bus ();

   riscv_fetch_exec #(.RESET_ADDR(32'h0000_0000), .DBG_REG(1)) dut (
      .clk     (clk),
      .reset   (reset),
      .bus     (bus),
      .dbg_reg (dbg_reg),
      .halted  (halted)
   );

   always #5 clk = ~clk;

   // Instruction memory: word returned the cycle after the strobe edge
   logic [31:0] mem [256];
   always @(posedge clk) begin
      if (bus.mem_rstrb) bus.mem_rdata <= mem[bus.mem_addr[9:2]];
   end

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   logic [31:0] m_regs [32];
   logic [31:0] m_pc;
   logic        m_halted;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1, "watchdog");
   end

   // ---------------- encoders ----------------
   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'h33};
   endfunction
   function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd, input logic [6:0] op);
      return {imm[11:0], rs1, f3, rd, op};
   endfunction
   function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                         input logic [2:0] f3);
      return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
   endfunction
   function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                         input logic [2:0] f3);
      return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
   endfunction
   function automatic logic [31:0] enc_u(input logic [31:0] val, input logic [4:0] rd, input logic [6:0] op);
      return {val[31:12], rd, op};
   endfunction
   function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
   endfunction
   function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [31:0] imm);
      return enc_i(imm, rs1, 3'd0, rd, 7'h13);
   endfunction

   // ---------------- reference model ----------------
   function automatic logic [31:0] alu_ref(input logic [2:0] f3, input logic sub, input logic sra,
                                           input logic [31:0] a, input logic [31:0] b);
      case (f3)
         3'd0: return sub ? a - b : a + b;
         3'd1: return a << b[4:0];
         3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         3'd3: return (a < b) ? 32'd1 : 32'd0;
         3'd4: return a ^ b;
         3'd5: return sra ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
         3'd6: return a | b;
         default: return a & b;
      endcase
   endfunction

   function automatic logic branch_ref(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      case (f3)
         3'd0: return a == b;
         3'd1: return a != b;
         3'd4: return $signed(a) < $signed(b);
         3'd5: return $signed(a) >= $signed(b);
         3'd6: return a < b;
         3'd7: return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_pc = '0;
      m_halted = 1'b0;
   endtask

   task automatic model_step();
      logic [31:0] ins, a, b, immi, immb, immu, immj, res, npc;
      logic        wr;
      ins  = mem[m_pc[9:2]];
      a    = m_regs[ins[19:15]];
      b    = m_regs[ins[24:20]];
      immi = {{20{ins[31]}}, ins[31:20]};
      immb = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
      immu = {ins[31:12], 12'h000};
      immj = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
      npc  = m_pc + 32'd4;
      wr   = 1'b0;
      res  = '0;
      if (ins == EBREAK) begin
         npc = m_pc;
         m_halted = 1'b1;
      end else begin
         case (ins[6:0])
            7'h37: begin wr = 1'b1; res = immu; end
            7'h17: begin wr = 1'b1; res = m_pc + immu; end
            7'h6f: begin wr = 1'b1; res = m_pc + 32'd4; npc = m_pc + immj; end
            7'h67: begin wr = 1'b1; res = m_pc + 32'd4; npc = (a + immi) & 32'hFFFF_FFFE; end
            7'h63: if (branch_ref(ins[14:12], a, b)) npc = m_pc + immb;
            7'h13: begin wr = 1'b1; res = alu_ref(ins[14:12], 1'b0, ins[30], a, immi); end
            7'h33: begin wr = 1'b1; res = alu_ref(ins[14:12], ins[30], ins[30], a, b); end
            default: ;
         endcase
      end
      if (wr && ins[11:7] != 5'd0) m_regs[ins[11:7]] = res;
      m_pc = npc;
   endtask

   // ---------------- stimulus helpers (sample points are always negedge+1) ----------------
   task automatic fill_mem();
      for (int i = 0; i < 256; i++) mem[i] = EBREAK;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      #1;
      n_checks++;
      if (bus.mem_rstrb !== 1'b0)
         begin n_errors++; $display("FAIL rstrb_in_reset: got %b want 0", bus.mem_rstrb); end
      @(negedge clk);
      reset = 1'b0;
      #1;
   endtask

   task automatic next_fetch(output logic ok, output logic [31:0] addr);
      ok = 1'b0;
      addr = '0;
      for (int i = 0; i < 6 && !ok; i++) begin
         if (bus.mem_rstrb === 1'b1) begin
            ok = 1'b1;
            addr = bus.mem_addr;
         end else begin
            @(posedge clk);
            @(negedge clk);
            #1;
         end
      end
   endtask

   task automatic exec_one();
      repeat (3) begin
         @(posedge clk);
         @(negedge clk);
      end
      #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      fill_mem();
      do_reset();
      n_checks++;
      if (halted !== 1'b0) begin n_errors++; $display("FAIL reset_halted: got %b want 0", halted); end
      n_checks++;
      if (dbg_reg !== 32'd0) begin n_errors++; $display("FAIL reset_dbg: got %h want 0", dbg_reg); end
      n_checks++;
      if (bus.mem_rstrb !== 1'b1 || bus.mem_addr !== 32'd0)
         begin n_errors++; $display("FAIL first_strobe: got rstrb=%b addr=%h want 1 and 0", bus.mem_rstrb, bus.mem_addr); end
      exec_one();
      n_checks++;
      if (halted !== 1'b1) begin n_errors++; $display("FAIL ebreak_halt: got %b want 1", halted); end
      do_reset();
      n_checks++;
      if (halted !== 1'b0 || bus.mem_rstrb !== 1'b1)
         begin n_errors++; $display("FAIL reset_from_halt: got halted=%b rstrb=%b want 0 and 1", halted, bus.mem_rstrb); end
   endtask

   task automatic test_counting_loop();
      int edges, strobes, halt_edge;
      fill_mem();
      mem[0] = enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd1);
      mem[1] = addi(5'd2, 5'd0, 32'd31);
      mem[2] = addi(5'd1, 5'd1, 32'd1);
      mem[3] = enc_b(-32'sd4, 5'd2, 5'd1, 3'd1);
      mem[4] = EBREAK;
      do_reset();
      edges = 0; strobes = 0; halt_edge = 0;
      repeat (260) begin
         if (bus.mem_rstrb === 1'b1) strobes++;
         @(posedge clk);
         edges++;
         @(negedge clk);
         #1;
         if (halted === 1'b1 && halt_edge == 0) halt_edge = edges;
      end
      n_checks++;
      if (halt_edge != 195) begin n_errors++; $display("FAIL loop_halt_edge: got %0d want 195", halt_edge); end
      n_checks++;
      if (strobes != 65) begin n_errors++; $display("FAIL loop_strobes: got %0d want 65", strobes); end
      n_checks++;
      if (dbg_reg !== 32'd31) begin n_errors++; $display("FAIL loop_dbg: got %h want 31", dbg_reg); end
   endtask

   task automatic test_jumps();
      logic        ok;
      logic [31:0] addr;
      logic [31:0] exp_addr [6];
      logic [31:0] exp_dbg  [6];
      fill_mem();
      mem[0] = enc_j(32'd8, 5'd5);
      mem[1] = enc_j(32'd10, 5'd0);
      mem[2] = enc_i(32'd3, 5'd5, 3'd0, 5'd6, 7'h67);
      mem[4] = enc_r(7'h00, 5'd0, 5'd5, 3'd0, 5'd1);
      mem[5] = enc_r(7'h00, 5'd0, 5'd6, 3'd0, 5'd1);
      exp_addr = '{32'd0, 32'd8, 32'd6, 32'd16, 32'd20, 32'd24};
      exp_dbg  = '{32'd0, 32'd0, 32'd0, 32'd4, 32'd12, 32'd12};
      do_reset();
      for (int i = 0; i < 6; i++) begin
         next_fetch(ok, addr);
         n_checks++;
         if (!ok || addr !== exp_addr[i])
            begin n_errors++; $display("FAIL jump_fetch[%0d]: got ok=%b addr=%h want %h", i, ok, addr, exp_addr[i]); end
         exec_one();
         n_checks++;
         if (dbg_reg !== exp_dbg[i])
            begin n_errors++; $display("FAIL jump_dbg[%0d]: got %h want %h", i, dbg_reg, exp_dbg[i]); end
      end
   endtask

   task automatic test_arith();
      logic [31:0] exp_dbg [7];
      fill_mem();
      mem[0] = enc_u(32'h8000_0000, 5'd1, 7'h37);
      mem[1] = enc_i(32'h404, 5'd1, 3'd5, 5'd3, 7'h13);
      mem[2] = enc_i(32'h004, 5'd1, 3'd5, 5'd4, 7'h13);
      mem[3] = enc_r(7'h00, 5'd1, 5'd0, 3'd3, 5'd7);
      mem[4] = enc_r(7'h00, 5'd0, 5'd3, 3'd0, 5'd1);
      mem[5] = enc_r(7'h00, 5'd0, 5'd4, 3'd0, 5'd1);
      mem[6] = enc_r(7'h00, 5'd0, 5'd7, 3'd0, 5'd1);
      exp_dbg = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
                  32'hF800_0000, 32'h0800_0000, 32'h0000_0001};
      do_reset();
      for (int i = 0; i < 7; i++) begin
         exec_one();
         n_checks++;
         if (dbg_reg !== exp_dbg[i])
            begin n_errors++; $display("FAIL arith_dbg[%0d]: got %h want %h", i, dbg_reg, exp_dbg[i]); end
      end
   endtask

   task automatic test_unsupported();
      logic        ok;
      logic [31:0] addr;
      fill_mem();
      mem[0] = addi(5'd1, 5'd0, 32'd9);
      mem[1] = enc_s(32'd1, 5'd1, 5'd0, 3'd2);
      mem[2] = enc_i(32'd0, 5'd0, 3'd2, 5'd1, 7'h03);
      mem[3] = 32'h0000_0000;
      mem[4] = 32'h0000_0073;
      do_reset();
      exec_one();
      for (int i = 1; i < 5; i++) begin
         exec_one();
         next_fetch(ok, addr);
         n_checks++;
         if (!ok || addr !== 32'(4 * (i + 1)))
            begin n_errors++; $display("FAIL nop_pc[%0d]: got ok=%b addr=%h want %h", i, ok, addr, 32'(4 * (i + 1))); end
         n_checks++;
         if (dbg_reg !== 32'd9 || halted !== 1'b0)
            begin n_errors++; $display("FAIL nop_state[%0d]: got dbg=%h halted=%b want 9 and 0", i, dbg_reg, halted); end
      end
   endtask

   task automatic test_reset_mid();
      fill_mem();
      mem[0] = addi(5'd1, 5'd0, 32'd5);
      do_reset();
      repeat (2) begin @(posedge clk); @(negedge clk); end
      reset = 1'b1;
      #1;
      n_checks++;
      if (bus.mem_rstrb !== 1'b0) begin n_errors++; $display("FAIL mid_rstrb: got %b want 0", bus.mem_rstrb); end
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      n_checks++;
      if (bus.mem_rstrb !== 1'b1 || bus.mem_addr !== 32'd0)
         begin n_errors++; $display("FAIL mid_refetch: got rstrb=%b addr=%h want 1 and 0", bus.mem_rstrb, bus.mem_addr); end
      n_checks++;
      if (dbg_reg !== 32'd0 || halted !== 1'b0)
         begin n_errors++; $display("FAIL mid_state: got dbg=%h halted=%b want 0 and 0", dbg_reg, halted); end
   endtask

   task automatic test_x0_halt();
      int strobes, drops, moves;
      fill_mem();
      mem[0] = addi(5'd1, 5'd0, 32'd3);
      mem[1] = addi(5'd0, 5'd0, 32'd7);
      mem[2] = enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd1);
      mem[3] = EBREAK;
      do_reset();
      exec_one();
      n_checks++;
      if (dbg_reg !== 32'd3) begin n_errors++; $display("FAIL x0_pre: got %h want 3", dbg_reg); end
      exec_one();
      exec_one();
      n_checks++;
      if (dbg_reg !== 32'd0) begin n_errors++; $display("FAIL x0_reads_zero: got %h want 0", dbg_reg); end
      exec_one();
      strobes = 0; drops = 0; moves = 0;
      repeat (20) begin
         if (bus.mem_rstrb !== 1'b0) strobes++;
         if (halted !== 1'b1) drops++;
         if (bus.mem_addr !== 32'd12) moves++;
         @(posedge clk);
         @(negedge clk);
         #1;
      end
      n_checks++;
      if (strobes != 0) begin n_errors++; $display("FAIL halt_strobes: got %0d want 0", strobes); end
      n_checks++;
      if (drops != 0) begin n_errors++; $display("FAIL halt_hold: got %0d low cycles want 0", drops); end
      n_checks++;
      if (moves != 0) begin n_errors++; $display("FAIL halt_pc: got %0d moved cycles want 0", moves); end
   endtask

   task automatic test_random(input int n_instr);
      logic        ok;
      logic [31:0] addr, imm;
      logic [4:0]  rd, rs1, rs2;
      logic [2:0]  f3;
      logic [2:0]  bf3 [6];
      bf3 = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
      fill_mem();
      for (int i = 0; i < n_instr; i++) begin
         rd  = 5'($urandom_range(0, 4));
         rs1 = 5'($urandom_range(0, 4));
         rs2 = 5'($urandom_range(0, 4));
         f3  = 3'($urandom_range(0, 7));
         imm = $urandom;
         case ($urandom_range(0, 9))
            0: mem[i] = enc_u(imm, rd, 7'h37);
            1: mem[i] = enc_u(imm, rd, 7'h17);
            2, 3: begin
               if (f3 == 3'd1) imm = {27'd0, imm[4:0]};
               if (f3 == 3'd5) imm = {21'd0, imm[10], 5'd0, imm[4:0]};
               mem[i] = enc_i(imm, rs1, f3, rd, 7'h13);
            end
            4, 5, 6: mem[i] = enc_r((f3 == 3'd0 || f3 == 3'd5) && imm[0] ? 7'h20 : 7'h00, rs2, rs1, f3, rd);
            7: mem[i] = enc_b(imm[0] ? 32'd8 : 32'd12, rs2, rs1, bf3[$urandom_range(0, 5)]);
            8: mem[i] = enc_j(32'd8, rd);
            default: mem[i] = enc_s(imm, rs2, rs1, 3'd2);
         endcase
      end
      model_reset();
      do_reset();
      for (int s = 0; s < n_instr + 4 && !m_halted; s++) begin
         next_fetch(ok, addr);
         n_checks++;
         if (!ok || addr !== m_pc)
            begin n_errors++; $display("FAIL rand_fetch[%0d]: got ok=%b addr=%h want %h", s, ok, addr, m_pc); end
         model_step();
         exec_one();
         n_checks++;
         if (dbg_reg !== m_regs[1])
            begin n_errors++; $display("FAIL rand_dbg[%0d]: got %h want %h", s, dbg_reg, m_regs[1]); end
         n_checks++;
         if (halted !== m_halted)
            begin n_errors++; $display("FAIL rand_halted[%0d]: got %b want %b", s, halted, m_halted); end
      end
   endtask

   initial begin
      reset = 1'b1;
      test_reset();
      test_counting_loop();
      test_jumps();
      test_arith();
      test_unsupported();
      test_reset_mid();
      test_x0_halt();
      repeat (4) test_random(40);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
